metronomo_tempo_ctrl: RTL and testbench

Tempo and measure controller for the metronome LED display. Generates a programmable beat tick, tracks beat position within a measure, drives the one-hot `leds` pattern at beat rate instead of clock rate, and flags the downbeat. Sits between the user/config interface and the LED outputs and replaces the free-running per-clock rotation with a start/stop, tempo-configurable sequence.

---
 rtl/metronomo_tempo_ctrl.sv | 178 +++++++++++++++++
 tb/tb_metronomo_tempo_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/metronomo_tempo_ctrl.sv
// Metronome tempo/measure controller: programmable beat tick, beat position,
// one-hot LED pattern at beat rate and downbeat flag, with start/stop control.
module metronomo_tempo_ctrl #(
   parameter int WIDTH      = 2,
   parameter int PW         = 16,
   parameter int DEF_PERIOD = 25000
) (
   input  logic                       clk_tb,
   input  logic                       rst_tb,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [PW-1:0]              cfg_period,
   input  logic [$clog2(WIDTH+1)-1:0] cfg_beats,
   output logic                       running,
   output logic                       beat_tick,
   output logic                       downbeat,
   output logic [$clog2(WIDTH)-1:0]   beat_idx,
   output logic [WIDTH-1:0]           leds
);

   localparam int BW = $clog2(WIDTH+1);
   localparam int IW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   cnt_reg, cnt_next;
   logic [PW-1:0]   period_reg, period_next;
   logic [BW-1:0]   beats_reg, beats_next;
   logic            pend_valid_reg, pend_valid_next;
   logic [PW-1:0]   pend_period_reg, pend_period_next;
   logic [BW-1:0]   pend_beats_reg, pend_beats_next;
   logic [IW-1:0]   idx_reg, idx_next;
   logic [WIDTH-1:0] leds_reg, leds_next;
   logic            tick_reg, tick_next;
   logic            down_reg, down_next;
   logic            running_reg, running_next;
   logic            cfg_ready_reg, cfg_ready_next;

   logic            cfg_acc;
   logic [PW-1:0]   clamp_period;
   logic [BW-1:0]   clamp_beats;
   logic [IW-1:0]   idx_adv;
   logic [WIDTH-1:0] led_dec;

   assign cfg_acc      = cfg_valid && cfg_ready_reg;
   assign clamp_period = (cfg_period < PW'(2)) ? PW'(2) : cfg_period;
   assign clamp_beats  = (cfg_beats == '0)          ? BW'(1) :
                         (cfg_beats > BW'(WIDTH))   ? BW'(WIDTH) : cfg_beats;
   assign idx_adv      = (BW'(idx_reg) == beats_reg - BW'(1)) ? '0 : idx_reg + IW'(1);

   // One-hot pattern for the beat about to begin
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led_dec
         assign led_dec[gi] = (idx_adv == IW'(gi));
      end
   endgenerate

   always_ff @(posedge clk_tb or negedge rst_tb) begin
      if (!rst_tb) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         period_reg      <= PW'(DEF_PERIOD);
         beats_reg       <= BW'(WIDTH);
         pend_valid_reg  <= 1'b0;
         pend_period_reg <= '0;
         pend_beats_reg  <= '0;
         idx_reg         <= '0;
         leds_reg        <= WIDTH'(1);
         tick_reg        <= 1'b0;
         down_reg        <= 1'b0;
         running_reg     <= 1'b0;
         cfg_ready_reg   <= 1'b1;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         period_reg      <= period_next;
         beats_reg       <= beats_next;
         pend_valid_reg  <= pend_valid_next;
         pend_period_reg <= pend_period_next;
         pend_beats_reg  <= pend_beats_next;
         idx_reg         <= idx_next;
         leds_reg        <= leds_next;
         tick_reg        <= tick_next;
         down_reg        <= down_next;
         running_reg     <= running_next;
         cfg_ready_reg   <= cfg_ready_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      period_next      = period_reg;
      beats_next       = beats_reg;
      pend_valid_next  = pend_valid_reg;
      pend_period_next = pend_period_reg;
      pend_beats_next  = pend_beats_reg;
      idx_next         = idx_reg;
      leds_next        = leds_reg;
      tick_next        = 1'b0;
      down_next        = 1'b0;
      running_next     = running_reg;
      cfg_ready_next   = cfg_ready_reg;
      case (state_reg)
         IDLE: begin
            if (cfg_acc) begin
               period_next = clamp_period;
               beats_next  = clamp_beats;
            end
            if (start && !stop) begin
               state_next   = RUN;
               running_next = 1'b1;
               cnt_next     = '0;
               idx_next     = '0;
               leds_next    = WIDTH'(1);
               tick_next    = 1'b1;
               down_next    = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_next      = IDLE;
               running_next    = 1'b0;
               cnt_next        = '0;
               idx_next        = '0;
               leds_next       = WIDTH'(1);
               pend_valid_next = 1'b0;
               cfg_ready_next  = 1'b1;
               if (pend_valid_reg) begin
                  period_next = pend_period_reg;
                  beats_next  = pend_beats_reg;
               end
               // An offer taken on the stop edge itself lands straight in the active registers
               if (cfg_acc) begin
                  period_next = clamp_period;
                  beats_next  = clamp_beats;
               end
            end else begin
               if (cfg_acc) begin
                  pend_valid_next  = 1'b1;
                  pend_period_next = clamp_period;
                  pend_beats_next  = clamp_beats;
                  cfg_ready_next   = 1'b0;
               end
               if (cnt_reg == period_reg - PW'(1)) begin
                  cnt_next  = '0;
                  idx_next  = idx_adv;
                  leds_next = led_dec;
                  tick_next = 1'b1;
                  if (idx_adv == '0) begin
                     down_next = 1'b1;
                     if (pend_valid_reg) begin
                        period_next     = pend_period_reg;
                        beats_next      = pend_beats_reg;
                        pend_valid_next = 1'b0;
                        cfg_ready_next  = 1'b1;
                     end
                  end
               end else begin
                  cnt_next = cnt_reg + PW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign cfg_ready = cfg_ready_reg;
   assign running   = running_reg;
   assign beat_tick = tick_reg;
   assign downbeat  = down_reg;
   assign beat_idx  = idx_reg;
   assign leds      = leds_reg;

endmodule

// File: tb/tb_metronomo_tempo_ctrl.sv
// Directed bench for metronomo_tempo_ctrl (WIDTH=2): cycle-by-cycle checks of
// ticks, LEDs, config handshake, stop/start and asynchronous reset.
module tb_metronomo_tempo_ctrl;

   logic        clk_tb;
   logic        rst_tb;
   logic        start;
   logic        stop;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_period;
   logic [1:0]  cfg_beats;
   logic        running;
   logic        beat_tick;
   logic        downbeat;
   logic [0:0]  beat_idx;
   logic [1:0]  leds;

   int checks = 0;
   int errors = 0;

   metronomo_tempo_ctrl #(.WIDTH(2), .PW(16), .DEF_PERIOD(25000)) dut (
      .clk_tb    (clk_tb),
      .rst_tb    (rst_tb),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_period(cfg_period),
      .cfg_beats (cfg_beats),
      .running   (running),
      .beat_tick (beat_tick),
      .downbeat  (downbeat),
      .beat_idx  (beat_idx),
      .leds      (leds)
   );

   initial clk_tb = 1'b0;
   always #5 clk_tb = ~clk_tb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit k of each mask describes cycle k: tick, downbeat, LED1 lit, cfg_ready low
   task automatic run_cycles(input string name, input int first, input int last,
                             input logic [31:0] tick_m, input logic [31:0] down_m,
                             input logic [31:0] led1_m, input logic [31:0] rdy0_m,
                             input logic exp_run);
      for (int k = first; k <= last; k++) begin
         @(posedge clk_tb);
         #1;
         check($sformatf("%s c%0d tick", name, k), 32'(beat_tick), 32'(tick_m[k]));
         check($sformatf("%s c%0d down", name, k), 32'(downbeat), 32'(down_m[k]));
         check($sformatf("%s c%0d leds", name, k), 32'(leds), led1_m[k] ? 32'd2 : 32'd1);
         check($sformatf("%s c%0d idx", name, k), 32'(beat_idx), 32'(led1_m[k]));
         check($sformatf("%s c%0d ready", name, k), 32'(cfg_ready), 32'(!rdy0_m[k]));
         check($sformatf("%s c%0d run", name, k), 32'(running), 32'(exp_run));
         $display("%s cycle %0d: tick=%0b down=%0b leds=%b idx=%0d ready=%0b run=%0b",
                  name, k, beat_tick, downbeat, leds, beat_idx, cfg_ready, running);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, " leds"}, 32'(leds), 32'd1);
      check({name, " idx"}, 32'(beat_idx), 32'd0);
      check({name, " run"}, 32'(running), 32'd0);
      check({name, " tick"}, 32'(beat_tick), 32'd0);
      check({name, " down"}, 32'(downbeat), 32'd0);
      check({name, " ready"}, 32'(cfg_ready), 32'd1);
   endtask

   localparam logic [31:0] Z = 32'd0;

   initial begin
      rst_tb     = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_beats  = '0;
      repeat (2) @(posedge clk_tb);
      #1;
      check_reset_vals("rst0");
      @(negedge clk_tb);
      rst_tb = 1'b1;

      // IDLE config period 4 beats 2, then run with mid-run period 3 offer
      cfg_valid = 1'b1; cfg_period = 16'd4; cfg_beats = 2'd2;
      run_cycles("idlecfg", 0, 0, Z, Z, Z, Z, 1'b0);
      cfg_valid = 1'b0;
      start = 1'b1;
      run_cycles("p1", 1, 1, 32'h9222, 32'h8202, 32'h71E0, 32'h0180, 1'b1);
      start = 1'b0;
      run_cycles("p1", 2, 6, 32'h9222, 32'h8202, 32'h71E0, 32'h0180, 1'b1);
      cfg_valid = 1'b1; cfg_period = 16'd3; cfg_beats = 2'd2;
      run_cycles("p1", 7, 7, 32'h9222, 32'h8202, 32'h71E0, 32'h0180, 1'b1);
      cfg_valid = 1'b0;
      run_cycles("p1", 8, 16, 32'h9222, 32'h8202, 32'h71E0, 32'h0180, 1'b1);

      // Stop, then start+stop together in IDLE
      stop = 1'b1;
      run_cycles("stop1", 17, 17, Z, Z, Z, Z, 1'b0);
      stop = 1'b0;
      run_cycles("stop1", 18, 20, Z, Z, Z, Z, 1'b0);
      start = 1'b1; stop = 1'b1;
      run_cycles("both", 1, 3, Z, Z, Z, Z, 1'b0);
      start = 1'b0; stop = 1'b0;

      // Clamp: period 0 -> 2, beats 3 -> 2; pending period 4 beats 0 committed by stop
      cfg_valid = 1'b1; cfg_period = 16'd0; cfg_beats = 2'd3;
      run_cycles("clampcfg", 0, 0, Z, Z, Z, Z, 1'b0);
      cfg_valid = 1'b0;
      start = 1'b1;
      run_cycles("p3", 1, 1, 32'h002A, 32'h0022, 32'h0018, 32'h0020, 1'b1);
      start = 1'b0;
      run_cycles("p3", 2, 4, 32'h002A, 32'h0022, 32'h0018, 32'h0020, 1'b1);
      cfg_valid = 1'b1; cfg_period = 16'd4; cfg_beats = 2'd0;
      run_cycles("p3", 5, 5, 32'h002A, 32'h0022, 32'h0018, 32'h0020, 1'b1);
      cfg_valid = 1'b0;
      stop = 1'b1;
      run_cycles("stop3", 6, 6, Z, Z, Z, Z, 1'b0);
      stop = 1'b0;
      run_cycles("stop3", 7, 8, Z, Z, Z, Z, 1'b0);

      // beats=1, period 4: every tick a downbeat; stop in third cycle of a beat
      start = 1'b1;
      run_cycles("p4", 1, 1, 32'h0222, 32'h0222, Z, Z, 1'b1);
      start = 1'b0;
      run_cycles("p4", 2, 11, 32'h0222, 32'h0222, Z, Z, 1'b1);
      stop = 1'b1;
      run_cycles("stop4", 12, 12, Z, Z, Z, Z, 1'b0);
      stop = 1'b0;
      run_cycles("stop4", 13, 16, Z, Z, Z, Z, 1'b0);

      // Restart: counter starts from 0
      start = 1'b1;
      run_cycles("p5", 1, 1, 32'h0022, 32'h0022, Z, Z, 1'b1);
      start = 1'b0;
      run_cycles("p5", 2, 5, 32'h0022, 32'h0022, Z, Z, 1'b1);
      stop = 1'b1;
      run_cycles("stop5", 6, 6, Z, Z, Z, Z, 1'b0);
      stop = 1'b0;

      // Back to beats 2, pending offer outstanding, then asynchronous reset mid-run
      cfg_valid = 1'b1; cfg_period = 16'd4; cfg_beats = 2'd2;
      run_cycles("p6cfg", 7, 7, Z, Z, Z, Z, 1'b0);
      cfg_valid = 1'b0;
      start = 1'b1;
      run_cycles("p6", 1, 1, 32'h0022, 32'h0002, 32'h0060, 32'h0040, 1'b1);
      start = 1'b0;
      run_cycles("p6", 2, 5, 32'h0022, 32'h0002, 32'h0060, 32'h0040, 1'b1);
      cfg_valid = 1'b1; cfg_period = 16'd3; cfg_beats = 2'd2;
      run_cycles("p6", 6, 6, 32'h0022, 32'h0002, 32'h0060, 32'h0040, 1'b1);
      cfg_valid = 1'b0;
      #3;
      rst_tb = 1'b0;
      #1;
      check_reset_vals("arst");
      $display("async reset asserted mid-run: leds=%b idx=%0d run=%0b ready=%0b",
               leds, beat_idx, running, cfg_ready);
      #96;
      @(negedge clk_tb);
      rst_tb = 1'b1;
      run_cycles("post", 1, 3, Z, Z, Z, Z, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
